// File: rtl/vga_glyph_capture_if.sv
// Port bundle for the glyph capture block: incoming video, capture
// request, and the glyph-memory write / status side.
interface vga_glyph_capture_if;
    logic       hsync;
    logic       vsync;
    logic [8:0] rgb_in;
    logic       start;
    logic [1:0] chr;
    logic [9:0] posx;
    logic [8:0] posy;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       err;

    // The capture block itself
    modport slave (
        input  hsync, vsync, rgb_in, start, chr, posx, posy,
        output wr_en, wr_addr, wr_data, busy, done, err
    );

    // Video source / requester side
    modport master (
        output hsync, vsync, rgb_in, start, chr, posx, posy,
        input  wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/vga_glyph_capture.sv
// Captures an 8x16 window of a 640x480 VGA stream into glyph memory,
// one byte per row (bit 7 = leftmost pixel), starting at a frame boundary.
module vga_glyph_capture (
    input  logic                 clk,
    input  logic                 reset,
    vga_glyph_capture_if.slave   bus
);
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int H_ACT  = 640;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;
    localparam int V_ACT  = 480;

    localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACT);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACT);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, FINISH} state_t;

    state_t     state, state_d;
    logic       hs_q, vs_q;
    logic [9:0] hcnt, vcnt;
    logic [1:0] chr_q;
    logic [9:0] posx_q;
    logic [8:0] posy_q;
    logic [7:0] shift_q;
    logic       wr_en_q;
    logic [5:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic       busy_q, done_q, err_q;

    logic       hs_fall, vs_fall;
    logic [9:0] x, y, col, row;
    logic       x_vld, y_vld, in_win, pix, win_ok, last_wr;
    logic       accept, reject, abort_c, finish_c, shift_en, row_end;
    logic       busy_d, done_d, err_d;

    // Sync edges, pixel coordinates and window membership for the current pixel
    always_comb begin
        hs_fall = hs_q & ~bus.hsync;
        vs_fall = vs_q & ~bus.vsync;
        x       = hcnt - H_START;
        y       = vcnt - V_START;
        x_vld   = (hcnt >= H_START) && (hcnt < H_END);
        y_vld   = (vcnt >= V_START) && (vcnt < V_END);
        col     = x - posx_q;
        row     = y - {1'b0, posy_q};
        in_win  = x_vld && y_vld && (x >= posx_q) && (col < 10'd8)
                  && (y >= {1'b0, posy_q}) && (row < 10'd16);
        pix     = |bus.rgb_in;
        win_ok  = (({1'b0, bus.posx} + 11'd8) <= 11'(H_ACT))
                  && (({1'b0, bus.posy} + 10'd16) <= 10'(V_ACT));
        // Row 15 is on the write port this cycle: the capture is complete
        last_wr = wr_en_q && (wr_addr_q[3:0] == 4'hF);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.start && win_ok) state_d = ARM;
            ARM:     if (vs_fall) state_d = CAPTURE;
            CAPTURE: begin
                if (last_wr)      state_d = FINISH;
                else if (vs_fall) state_d = IDLE;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control decode; status outputs are registered from these
    always_comb begin
        accept   = (state == IDLE) && bus.start && win_ok;
        reject   = (state == IDLE) && bus.start && !win_ok;
        abort_c  = (state == CAPTURE) && !last_wr && vs_fall;
        finish_c = (state == CAPTURE) && last_wr;
        shift_en = (state == CAPTURE) && !abort_c && in_win;
        row_end  = shift_en && (col[2:0] == 3'd7);
        busy_d   = (state_d == ARM) || (state_d == CAPTURE);
        done_d   = finish_c;
        err_d    = reject || abort_c;
    end

    // Sync tracking, counters, request latch, row assembly and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            hcnt      <= '0;
            vcnt      <= '0;
            chr_q     <= '0;
            posx_q    <= '0;
            posy_q    <= '0;
            shift_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            hs_q <= bus.hsync;
            vs_q <= bus.vsync;

            if (hs_fall)                hcnt <= '0;
            else if (hcnt != 10'h3FF)   hcnt <= hcnt + 10'd1;

            // vsync wins when both edges land together
            if (vs_fall)      vcnt <= '0;
            else if (hs_fall) vcnt <= vcnt + 10'd1;

            if (accept) begin
                chr_q  <= bus.chr;
                posx_q <= bus.posx;
                posy_q <= bus.posy;
            end

            wr_en_q <= row_end;
            if (accept) begin
                shift_q <= '0;
            end else if (row_end) begin
                wr_addr_q <= {chr_q, row[3:0]};
                wr_data_q <= {shift_q[6:0], pix};
                shift_q   <= '0;
            end else if (shift_en) begin
                shift_q <= {shift_q[6:0], pix};
            end

            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_vga_glyph_capture.sv
// Bench for vga_glyph_capture: drives VGA-style line/frame timing with a
// painted glyph window, queues expected writes/done/err, and a negedge
// monitor pops and compares each event the DUT presents.
module tb_vga_glyph_capture;
    // Lines are cut short: the DUT only needs hsync edges and the first
    // few active pixels, and this keeps the run small.
    localparam int LINE   = 180;
    localparam int K_WR   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int         kind;
        logic [5:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    vga_glyph_capture_if bus();

    vga_glyph_capture dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] rows[16];
    int         wx, wy;
    bit         alt_mode = 1'b0;
    int         act_kind = 0, act_l = 0, act_p = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input int k, input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = k; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none",
                     k, bus.wr_addr, bus.wr_data);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            if (k == K_WR) begin
                chk("wr_addr", bus.wr_addr, e.addr);
                chk("wr_data", bus.wr_data, e.data);
            end
        end
    endtask

    // Monitor: every output event is matched against the scoreboard in order
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) observe(K_WR);
        if (bus.done  === 1'b1) observe(K_DONE);
        if (bus.err   === 1'b1) observe(K_ERR);
    end

    // Pixel colour for line l / cycle p of a frame as seen by the DUT counters
    function automatic logic [8:0] pix(input int l, input int p);
        int x, y;
        if (p < 145 || l < 35) return 9'h000;
        x = p - 145;
        y = l - 35;
        if (alt_mode) return (x % 2 == 0) ? 9'h1FF : 9'h000;
        if (x >= wx && x < wx + 8 && y >= wy && y < wy + 16)
            return rows[y - wy][7 - (x - wx)] ? ((x % 2) ? 9'h001 : 9'h100) : 9'h000;
        return 9'h0A5;
    endfunction

    task automatic idle(input int n);
        bus.hsync = 1'b1; bus.vsync = 1'b1; bus.rgb_in = '0; bus.start = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input logic [1:0] c, input logic [9:0] px, input logic [8:0] py);
        bus.start = 1'b1; bus.chr = c; bus.posx = px; bus.posy = py;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // One frame of nl lines; act_kind 1 injects a second start, 2 a reset pulse
    task automatic run_frame(input int nl);
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < LINE; p++) begin
                bus.hsync  = (p >= 96);
                bus.vsync  = (l >= 2);
                bus.rgb_in = pix(l, p);
                bus.start  = 1'b0;
                if (act_kind == 1 && l == act_l && p == act_p) begin
                    bus.start = 1'b1; bus.chr = 2'd0; bus.posx = 10'd0; bus.posy = 9'd0;
                end
                reset = !(act_kind == 2 && l == act_l && p >= act_p && p < act_p + 3);
                @(posedge clk); #1;
                if (act_kind == 2 && l == act_l && p == act_p) begin
                    chk("rst_mid_wr_en",   bus.wr_en,   0);
                    chk("rst_mid_wr_addr", bus.wr_addr, 0);
                    chk("rst_mid_wr_data", bus.wr_data, 0);
                    chk("rst_mid_busy",    bus.busy,    0);
                    chk("rst_mid_done",    bus.done,    0);
                    chk("rst_mid_err",     bus.err,     0);
                end
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hsync = 1'b1; bus.vsync = 1'b1; bus.rgb_in = '0;
        bus.start = 1'b0; bus.chr = '0; bus.posx = '0; bus.posy = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",   bus.wr_en,   0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_busy",    bus.busy,    0);
        chk("rst_done",    bus.done,    0);
        chk("rst_err",     bus.err,     0);
        reset = 1'b1;
        idle(10);

        // Solid 0x3C glyph, chr 2 at (8,16)
        wx = 8; wy = 16;
        for (int r = 0; r < 16; r++) begin
            rows[r] = 8'h3C;
            push(K_WR, {2'd2, 4'(r)}, 8'h3C);
        end
        push(K_DONE, '0, '0);
        issue(2'd2, 10'd8, 9'd16);
        chk("t1_busy_start", bus.busy, 1);
        chk("t1_err_start",  bus.err,  0);
        run_frame(67);
        idle(4);
        chk("t1_busy_end", bus.busy, 0);

        // Out-of-range windows rejected; exact-fit window accepted then aborted
        push(K_ERR, '0, '0);
        issue(2'd1, 10'd636, 9'd0);
        chk("t2_err_x",   bus.err,  1);
        chk("t2_busy_x",  bus.busy, 0);
        idle(1);
        chk("t2_err_one_cycle", bus.err, 0);
        push(K_ERR, '0, '0);
        issue(2'd0, 10'd0, 9'd465);
        chk("t2_err_y",  bus.err,  1);
        chk("t2_busy_y", bus.busy, 0);
        idle(2);
        wx = 632; wy = 464;
        issue(2'd3, 10'd632, 9'd464);
        chk("t2_busy_edge", bus.busy, 1);
        chk("t2_err_edge",  bus.err,  0);
        run_frame(3);
        chk("t2_busy_capture", bus.busy, 1);
        push(K_ERR, '0, '0);
        run_frame(3);
        idle(2);
        chk("t2_busy_abort", bus.busy, 0);

        // Distinct rows, chr 1 at (20,4); a second start mid-capture is ignored
        wx = 20; wy = 4;
        for (int r = 0; r < 16; r++) begin
            rows[r] = {4'(r), ~4'(r)};
            push(K_WR, {2'd1, 4'(r)}, {4'(r), ~4'(r)});
        end
        push(K_DONE, '0, '0);
        issue(2'd1, 10'd20, 9'd4);
        act_kind = 1; act_l = 41; act_p = 100;
        run_frame(55);
        act_kind = 0;
        idle(4);
        chk("t3_busy_end", bus.busy, 0);

        // Early vsync after 5 rows aborts the capture
        wx = 3; wy = 2;
        for (int r = 0; r < 16; r++) rows[r] = (8'h80 >> r) | 8'h01;
        for (int r = 0; r < 5; r++) push(K_WR, {2'd0, 4'(r)}, (8'h80 >> r) | 8'h01);
        push(K_ERR, '0, '0);
        issue(2'd0, 10'd3, 9'd2);
        run_frame(42);
        run_frame(3);
        idle(4);
        chk("t4_busy_end", bus.busy, 0);

        // Reset after row 3; no further writes, even across a new frame
        wx = 8; wy = 0;
        for (int r = 0; r < 16; r++) rows[r] = 8'hF0 | 8'(r);
        for (int r = 0; r < 4; r++) push(K_WR, {2'd2, 4'(r)}, 8'hF0 | 8'(r));
        issue(2'd2, 10'd8, 9'd0);
        act_kind = 2; act_l = 38; act_p = 170;
        run_frame(52);
        act_kind = 0;
        run_frame(38);
        idle(4);
        chk("t5_busy_end", bus.busy, 0);

        // Alternating pixels at the origin, chr 3
        alt_mode = 1'b1; wx = 0; wy = 0;
        for (int r = 0; r < 16; r++) push(K_WR, {2'd3, 4'(r)}, 8'hAA);
        push(K_DONE, '0, '0);
        issue(2'd3, 10'd0, 9'd0);
        run_frame(52);
        idle(4);
        alt_mode = 1'b0;
        chk("t6_busy_end", bus.busy, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_glyph_capture.md
VGA_GLYPH_CAPTURE -- requirements
Module: vga_glyph_capture

Interface
REQ-001 clk  input  1  pixel clock; one pixel per cycle; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-low; sampled on the rising edge of clk.
REQ-003 hsync  input  1  incoming horizontal sync, active low.
REQ-004 vsync  input  1  incoming vertical sync, active low.
REQ-005 rgb_in  input  9  incoming pixel colour; a pixel is "on" when the value is nonzero.
REQ-006 start  input  1  single-cycle capture request.
REQ-007 chr  input  2  target glyph slot; latched when start is accepted.
REQ-008 posx  input  10  window left edge, in active-pixel coordinates; latched when start is accepted.
REQ-009 posy  input  9  window top edge, in active-line coordinates; latched when start is accepted.
REQ-010 wr_en  output  1  glyph memory write strobe, one cycle per row.
REQ-011 wr_addr  output  6  write address {chr, row[3:0]}.
REQ-012 wr_data  output  8  row bitmap; bit 7 is the leftmost pixel.
REQ-013 busy  output  1  high from start acceptance until done or err.
REQ-014 done  output  1  one-cycle pulse after row 15 is written.
REQ-015 err  output  1  one-cycle pulse on rejected start or aborted capture.

Function
REQ-016 Timing constants: H_SYNC=96, H_BP=48, H_ACT=640; V_SYNC=2, V_BP=33, V_ACT=480.
REQ-017 hsync and vsync shall each be registered once; a falling edge is registered value 1 while the current input is 0.
REQ-018 hcnt (10 bits) shall clear to 0 in the cycle an hsync falling edge is detected; otherwise it increments, saturating at 1023.
REQ-019 vcnt (10 bits) shall clear to 0 on a vsync falling edge; otherwise it increments on each hsync falling edge; vsync takes priority when both edges coincide.
REQ-020 Active pixel coordinates: x = hcnt-144, valid when 144<=hcnt<784; y = vcnt-35, valid when 35<=vcnt<515.
REQ-021 States: IDLE, ARM, CAPTURE, FINISH.
REQ-022 IDLE with start=1 and window inside the active area (posx+8<=640, posy+16<=480): latch chr, posx and posy, set busy, and go to ARM.
REQ-023 IDLE with start=1 and window outside the active area: pulse err the next cycle, leave busy low, and stay in IDLE.
REQ-024 start while not in IDLE shall be ignored, with no err pulse.
REQ-025 ARM: wait for a vsync falling edge, then go to CAPTURE; capture always begins at a frame start.
REQ-026 CAPTURE: when x and y are valid, posx<=x<posx+8 and posy<=y<posy+16, shift (rgb_in!=0) into an 8-bit register MSB-first.
REQ-027 On the 8th pixel of a row, the next cycle shall drive wr_en=1, wr_data=the assembled byte and wr_addr={chr, y-posy}, then clear the shift register.
REQ-028 After row 15 is written, go to FINISH; FINISH pulses done for one cycle, clears busy, and returns to IDLE.
REQ-029 A vsync falling edge while in CAPTURE, before row 15 is written, shall abort: pulse err, clear busy, go to IDLE, and drive no further wr_en.
REQ-030 wr_en shall never be asserted outside CAPTURE and never more than 16 times per capture; done and err are mutually exclusive.
REQ-031 wr_addr row arithmetic is 4-bit and shall not wrap within a capture.

Reset
REQ-032 With reset=0: state=IDLE; hcnt=vcnt=0; sync registers=1; shift register=0; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0.
REQ-033 reset asserted mid-capture shall take effect on the next edge; no write and no done/err pulse follow it.
REQ-034 After reset release, capture requires a new start and a new vsync falling edge.

Verification
REQ-035 Standard 800x525 frames, glyph 0x3C in every row at posx=8, posy=16, chr=2, start in IDLE -> 16 writes, wr_addr 0x20..0x2F, wr_data 0x3C each, then done, busy=0.
REQ-036 start with posx=636 -> err pulse one cycle later, busy stays 0, no wr_en.
REQ-037 start then early vsync falling edge after 5 rows -> exactly 5 writes, err pulse, no done.
REQ-038 Second start during CAPTURE with a different chr -> ignored; all wr_addr values use the original chr.
REQ-039 reset=0 after row 3 is written -> all outputs 0 next cycle; no further wr_en until a new start plus vsync.
REQ-040 Alternating on/off pixels (rgb_in 0x1FF/0x000) at posx=0, posy=0 -> every wr_data = 0xAA.
